// File: rtl/lc3b_ctrl_pipe_pkg.sv
// lc3b_ctrl_pipe_pkg
//   Shared types for the LC-3b control pipeline.
//   - lc3b_control_word: the decoded control word, as one packed struct.
//   - LC3B_CTRL_W: the width of that struct.
//   - lc3b_pipe_entry: one pipeline slot, {valid, pc, ir, ctrl}.
//   - LC3B_PIPE_STAGES: the default pipeline depth.
//   An all-zero control word is a no-op: nothing is loaded and no memory
//   access is made. Invalid and bubble stages rely on this.
package lc3b_ctrl_pipe_pkg;

  localparam int LC3B_PIPE_STAGES = 4;
  localparam int LC3B_WORD_W      = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_NOT  = 4'd2,
    ALU_PASS = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6
  } lc3b_aluop;

  typedef enum logic [1:0] {
    PCMUX_INC = 2'd0,
    PCMUX_BR  = 2'd1,
    PCMUX_REG = 2'd2,
    PCMUX_MEM = 2'd3
  } lc3b_pcmux_sel;

  typedef struct packed {
    lc3b_aluop     aluop;
    logic          load_regfile;
    logic          load_cc;
    logic          mem_read;
    logic          mem_write;
    logic          load_pc;
    lc3b_pcmux_sel pcmux_sel;
    logic          marmux_sel;
    logic [1:0]    mdrmux_sel;
    logic          regfile_sel;
    logic          br_en;
  } lc3b_control_word;

  localparam int LC3B_CTRL_W = $bits(lc3b_control_word);

  typedef struct packed {
    logic             valid;
    lc3b_word         pc;
    lc3b_word         ir;
    lc3b_control_word ctrl;
  } lc3b_pipe_entry;

  // Returns 1 when a control word has no architectural side effect.
  function automatic logic ctrl_is_nop(input lc3b_control_word cw);
    return !(cw.load_regfile || cw.load_cc || cw.mem_read || cw.mem_write || cw.load_pc);
  endfunction

endpackage

// File: rtl/lc3b_ctrl_pipe_if.sv
// lc3b_ctrl_pipe_if
//   Decoder-to-pipeline issue bus.
//   Signals:
//     valid - the decoder presents an instruction
//     pc    - PC of that instruction
//     ir    - instruction word
//     ctrl  - decoded control word
//     ready - the pipeline accepts the instruction this cycle
//   Modports:
//     master - the decoder (drives valid/pc/ir/ctrl, reads ready)
//     slave  - the pipeline (reads valid/pc/ir/ctrl, drives ready)
interface lc3b_ctrl_pipe_if #(
  parameter int WORD_W = 16,
  parameter int CTRL_W = 16
);
  logic              valid;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] ir;
  logic [CTRL_W-1:0] ctrl;
  logic              ready;

  modport master (output valid, output pc, output ir, output ctrl, input ready);
  modport slave  (input valid, input pc, input ir, input ctrl, output ready);
endinterface

// File: rtl/lc3b_ctrl_pipe_stage_reg.sv
// lc3b_pipe_stage_reg
//   One pipeline entry register, with a synchronous active-low reset.
//   Priority of the controls: squash > bubble > load > hold.
//   Ports:
//     clk, rst_n                      - clock and synchronous active-low reset
//     load, bubble, squash            - per-stage controls computed by the parent
//     d_valid, d_pc, d_ir, d_ctrl     - entry offered by the previous stage
//     q_valid, q_pc, q_ir, q_ctrl     - registered entry
//   The control word is stored as zero whenever the stored entry is invalid.
//   Downstream logic can therefore use q_ctrl without looking at q_valid.
module lc3b_pipe_stage_reg #(
  parameter int WORD_W = 16,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              squash,
  input  logic              d_valid,
  input  logic [WORD_W-1:0] d_pc,
  input  logic [WORD_W-1:0] d_ir,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_valid,
  output logic [WORD_W-1:0] q_pc,
  output logic [WORD_W-1:0] q_ir,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_ir    <= '0;
      q_ctrl  <= '0;
    end else if (squash) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_ir    <= '0;
      q_ctrl  <= '0;
    end else if (bubble) begin
      // pc/ir are kept; they are meaningless once valid is low.
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_pc    <= d_pc;
      q_ir    <= d_ir;
      q_ctrl  <= d_valid ? d_ctrl : '0;
    end
  end

endmodule

// File: rtl/lc3b_ctrl_pipe.sv
// lc3b_ctrl_pipe
//   In-order pipeline of {valid, pc, ir, control word} entries.
//   It runs from the decoder to writeback and supports hold (stall),
//   bubble insertion and squash (flush).
//   Stage 0 is the youngest stage. Stage k drives datapath stage k+1.
//   Stage STAGES-1 feeds writeback and is also presented as out_*.
//   Ports:
//     clk, rst_n                 - clock and synchronous active-low reset
//     in_bus (slave)             - issue bus from the decoder
//                                  (valid/pc/ir/ctrl in, ready out)
//     stall_en, stall_stage      - hold stages 0..stall_stage
//     flush_en, flush_stage      - squash stages 0..flush_stage
//     stg_valid/pc/ir/ctrl       - flattened per-stage contents;
//                                  stage k sits at [k*W +: W]
//     out_valid/pc/ir/ctrl       - the contents of the oldest stage
//   Optional feature, enabled by defining the macro LC3B_PIPE_PERF_EN:
//     perf_stall_cnt, perf_flush_cnt, perf_retire_cnt
//     These are saturating 32-bit event counters.
//   in_bus.ready is the only combinational output. Every stg_* and out_*
//   signal comes straight from a register.
module lc3b_ctrl_pipe
  import lc3b_ctrl_pipe_pkg::*;
#(
  parameter int STAGES = LC3B_PIPE_STAGES,
  parameter int WORD_W = LC3B_WORD_W,
  parameter int CTRL_W = LC3B_CTRL_W,
  parameter int SIDX_W = $clog2(STAGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lc3b_ctrl_pipe_if.slave            in_bus,
  input  logic                       stall_en,
  input  logic [SIDX_W-1:0]          stall_stage,
  input  logic                       flush_en,
  input  logic [SIDX_W-1:0]          flush_stage,
  output logic [STAGES-1:0]          stg_valid,
  output logic [STAGES*WORD_W-1:0]   stg_pc,
  output logic [STAGES*WORD_W-1:0]   stg_ir,
  output logic [STAGES*CTRL_W-1:0]   stg_ctrl,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_ir,
  output logic [CTRL_W-1:0]          out_ctrl
`ifdef LC3B_PIPE_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_flush_cnt,
  output logic [31:0]                perf_retire_cnt
`endif
);

  localparam int LAST = STAGES - 1;

  int                s_idx;
  int                f_idx;
  logic [STAGES-1:0] hold_k;
  logic [STAGES-1:0] load_k;
  logic [STAGES-1:0] bubble_k;
  logic [STAGES-1:0] squash_k;

  logic [WORD_W-1:0] q_pc   [STAGES];
  logic [WORD_W-1:0] q_ir   [STAGES];
  logic [CTRL_W-1:0] q_ctrl [STAGES];

  assign in_bus.ready = !stall_en;

  // A stage index beyond the last stage is treated as the last stage.
  always_comb begin
    s_idx = (int'(stall_stage) > LAST) ? LAST : int'(stall_stage);
    f_idx = (int'(flush_stage) > LAST) ? LAST : int'(flush_stage);
  end

  // Stall: stages 0..s hold and stage s+1 takes a bubble.
  // Flush: stages 0..f are squashed. The instruction leaving stage f is
  // squashed as well, so stage f+1 loads an invalid entry unless it is
  // being held by a stall.
  always_comb begin
    hold_k   = '0;
    load_k   = '0;
    bubble_k = '0;
    squash_k = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold_k[k]   = stall_en && (k <= s_idx);
      bubble_k[k] = stall_en && (k == s_idx + 1);
      load_k[k]   = !hold_k[k];
      squash_k[k] = flush_en && ((k <= f_idx) || ((k == f_idx + 1) && !hold_k[k]));
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              d_valid;
    logic [WORD_W-1:0] d_pc;
    logic [WORD_W-1:0] d_ir;
    logic [CTRL_W-1:0] d_ctrl;

    if (k == 0) begin : g_head
      assign d_valid = in_bus.valid;
      assign d_pc    = in_bus.pc;
      assign d_ir    = in_bus.ir;
      assign d_ctrl  = in_bus.ctrl;
    end else begin : g_body
      assign d_valid = stg_valid[k-1];
      assign d_pc    = q_pc[k-1];
      assign d_ir    = q_ir[k-1];
      assign d_ctrl  = q_ctrl[k-1];
    end

    lc3b_pipe_stage_reg #(
      .WORD_W (WORD_W),
      .CTRL_W (CTRL_W)
    ) u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_k[k]),
      .bubble  (bubble_k[k]),
      .squash  (squash_k[k]),
      .d_valid (d_valid),
      .d_pc    (d_pc),
      .d_ir    (d_ir),
      .d_ctrl  (d_ctrl),
      .q_valid (stg_valid[k]),
      .q_pc    (q_pc[k]),
      .q_ir    (q_ir[k]),
      .q_ctrl  (q_ctrl[k])
    );

    assign stg_pc[k*WORD_W +: WORD_W]   = q_pc[k];
    assign stg_ir[k*WORD_W +: WORD_W]   = q_ir[k];
    assign stg_ctrl[k*CTRL_W +: CTRL_W] = q_ctrl[k];
  end

  assign out_valid = stg_valid[LAST];
  assign out_pc    = q_pc[LAST];
  assign out_ir    = q_ir[LAST];
  assign out_ctrl  = q_ctrl[LAST];

`ifdef LC3B_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_retire_cnt <= '0;
    end else begin
      if (stall_en && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_en && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (out_valid && (perf_retire_cnt != 32'hFFFF_FFFF))
        perf_retire_cnt <= perf_retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
module tb_lc3b_ctrl_pipe;

  localparam int STAGES = 4;
  localparam int WORD_W = 16;
  localparam int CTRL_W = 16;
  localparam int SIDX_W = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     stall_en;
  logic [SIDX_W-1:0]        stall_stage;
  logic                     flush_en;
  logic [SIDX_W-1:0]        flush_stage;
  logic [STAGES-1:0]        stg_valid;
  logic [STAGES*WORD_W-1:0] stg_pc;
  logic [STAGES*WORD_W-1:0] stg_ir;
  logic [STAGES*CTRL_W-1:0] stg_ctrl;
  logic                     out_valid;
  logic [WORD_W-1:0]        out_pc;
  logic [WORD_W-1:0]        out_ir;
  logic [CTRL_W-1:0]        out_ctrl;
`ifdef LC3B_PIPE_PERF_EN
  logic [31:0]              perf_stall_cnt;
  logic [31:0]              perf_flush_cnt;
  logic [31:0]              perf_retire_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  lc3b_ctrl_pipe_if #(.WORD_W(WORD_W), .CTRL_W(CTRL_W)) bus ();

  lc3b_ctrl_pipe #(
    .STAGES (STAGES),
    .WORD_W (WORD_W),
    .CTRL_W (CTRL_W),
    .SIDX_W (SIDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bus      (bus.slave),
    .stall_en    (stall_en),
    .stall_stage (stall_stage),
    .flush_en    (flush_en),
    .flush_stage (flush_stage),
    .stg_valid   (stg_valid),
    .stg_pc      (stg_pc),
    .stg_ir      (stg_ir),
    .stg_ctrl    (stg_ctrl),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_ir      (out_ir),
    .out_ctrl    (out_ctrl)
`ifdef LC3B_PIPE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_retire_cnt (perf_retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] ir,
                       input logic [15:0] ctrl);
    bus.valid = v;
    bus.pc    = pc;
    bus.ir    = ir;
    bus.ctrl  = ctrl;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    stall_en    = 1'b0;
    stall_stage = '0;
    flush_en    = 1'b0;
    flush_stage = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // After fill: stage 3 = base, stage 2 = base+2, stage 1 = base+4, stage 0 = base+6.
  // Instruction i carries ctrl = cbase + i.
  task automatic fill(input logic [15:0] base, input logic [15:0] cbase);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(base + 16'(2 * i)), 16'(16'hA000 + 16'(i)), 16'(cbase + 16'(i)));
      step();
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    drive(1'b1, 16'h1234, 16'h5678, 16'hFFFF);
    step();
    step();
    if (stg_valid !== 4'b0000) begin
      $display("FAIL reset_valid_in_reset: got %b expected 0000", stg_valid); failures++;
    end
    checks++;
    rst_n = 1'b1;
    idle();
    #1;
    if (bus.ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", bus.ready); failures++;
    end
    checks++;
    if (out_ctrl !== 16'h0) begin
      $display("FAIL reset_out_ctrl: got %h expected 0000", out_ctrl); failures++;
    end
    checks++;
    if (stg_pc !== 64'h0) begin
      $display("FAIL reset_stg_pc: got %h expected 0", stg_pc); failures++;
    end
    checks++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 4)
        drive(1'b1, 16'(16'h3000 + 16'(2 * cyc)), 16'(16'h1000 + 16'(cyc)), 16'(16'h0100 + 16'(cyc)));
      else
        bus.valid = 1'b0;
      step();
      if (cyc == 2) begin
        if (out_valid !== 1'b0) begin
          $display("FAIL stream_early: got %b expected 0", out_valid); failures++;
        end
        checks++;
      end
      if (cyc >= 3 && cyc <= 6) begin
        if (out_valid !== 1'b1 || out_pc !== 16'(16'h3000 + 16'(2 * (cyc - 3)))) begin
          $display("FAIL stream_out: cyc %0d got v=%b pc=%h expected v=1 pc=%h", cyc, out_valid,
                   out_pc, 16'(16'h3000 + 16'(2 * (cyc - 3)))); failures++;
        end
        checks++;
        if (out_ctrl !== 16'(16'h0100 + 16'(cyc - 3)) || out_ir !== 16'(16'h1000 + 16'(cyc - 3))) begin
          $display("FAIL stream_ctrl_ir: cyc %0d got ctrl=%h ir=%h", cyc, out_ctrl, out_ir); failures++;
        end
        checks++;
      end
      if (cyc == 7) begin
        if (out_valid !== 1'b0) begin
          $display("FAIL stream_drain: got %b expected 0", out_valid); failures++;
        end
        checks++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fill(16'h4000, 16'h0400);
    stall_en    = 1'b1;
    stall_stage = 2'd1;
    drive(1'b1, 16'h4EEE, 16'hEEEE, 16'hEEEE);
    #1;
    if (bus.ready !== 1'b0) begin
      $display("FAIL stall_ready: got %b expected 0", bus.ready); failures++;
    end
    checks++;
    step();
    if (stg_valid !== 4'b1011 || stg_pc[15:0] !== 16'h4006 || stg_pc[31:16] !== 16'h4004 ||
        out_pc !== 16'h4002 || stg_ctrl[47:32] !== 16'h0) begin
      $display("FAIL stall_cycle1: got valid=%b pc=%h ctrl=%h expected valid=1011 pc=4002_xxxx_4004_4006",
               stg_valid, stg_pc, stg_ctrl); failures++;
    end
    checks++;
    step();
    if (stg_valid !== 4'b0011 || stg_pc[15:0] !== 16'h4006 || stg_pc[31:16] !== 16'h4004 ||
        out_ctrl !== 16'h0) begin
      $display("FAIL stall_cycle2: got valid=%b pc=%h out_ctrl=%h expected valid=0011", stg_valid,
               stg_pc, out_ctrl); failures++;
    end
    checks++;
    stall_en = 1'b0;
    drive(1'b1, 16'h4008, 16'hA004, 16'h0404);
    step();
    bus.valid = 1'b0;
    if (stg_valid !== 4'b0111 || stg_pc[15:0] !== 16'h4008 || stg_pc[47:32] !== 16'h4004) begin
      $display("FAIL stall_release: got valid=%b pc=%h expected valid=0111", stg_valid, stg_pc);
      failures++;
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b1 || out_pc !== 16'(16'h4004 + 16'(2 * i)) ||
          out_ctrl !== 16'(16'h0402 + 16'(i))) begin
        $display("FAIL stall_drain: step %0d got v=%b pc=%h ctrl=%h expected pc=%h", i, out_valid,
                 out_pc, out_ctrl, 16'(16'h4004 + 16'(2 * i))); failures++;
      end
      checks++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill(16'h5000, 16'h0500);
    flush_en    = 1'b1;
    flush_stage = 2'd1;
    drive(1'b1, 16'h5008, 16'hA004, 16'h0504);
    #1;
    if (bus.ready !== 1'b1) begin
      $display("FAIL flush_ready: got %b expected 1", bus.ready); failures++;
    end
    checks++;
    step();
    idle();
    if (stg_valid !== 4'b1000 || stg_ctrl[47:0] !== 48'h0) begin
      $display("FAIL flush_valid: got valid=%b ctrl=%h expected valid=1000 low ctrl 0", stg_valid,
               stg_ctrl); failures++;
    end
    checks++;
    if (out_pc !== 16'h5002 || out_ctrl !== 16'h0501) begin
      $display("FAIL flush_survivor: got pc=%h ctrl=%h expected pc=5002 ctrl=0501", out_pc, out_ctrl);
      failures++;
    end
    checks++;
    step();
    if (stg_valid !== 4'b0000) begin
      $display("FAIL flush_after: got %b expected 0000", stg_valid); failures++;
    end
    checks++;
  endtask

  task automatic test_stall_flush();
    do_reset();
    fill(16'h6000, 16'h0600);
    stall_en    = 1'b1;
    stall_stage = 2'd2;
    flush_en    = 1'b1;
    flush_stage = 2'd0;
    drive(1'b1, 16'h6EEE, 16'hEEEE, 16'hEEEE);
    #1;
    if (bus.ready !== 1'b0) begin
      $display("FAIL sf_ready: got %b expected 0", bus.ready); failures++;
    end
    checks++;
    step();
    idle();
    if (stg_valid !== 4'b0110 || out_valid !== 1'b0 || out_ctrl !== 16'h0) begin
      $display("FAIL sf_valid: got valid=%b out_ctrl=%h expected valid=0110 out_ctrl=0", stg_valid,
               out_ctrl); failures++;
    end
    checks++;
    if (stg_pc[31:16] !== 16'h6004 || stg_pc[47:32] !== 16'h6002 || stg_ctrl[15:0] !== 16'h0 ||
        stg_ctrl[31:16] !== 16'h0602 || stg_ctrl[47:32] !== 16'h0601) begin
      $display("FAIL sf_content: got pc=%h ctrl=%h", stg_pc, stg_ctrl); failures++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    fill(16'h7000, 16'h0700);
    stall_en    = 1'b1;
    stall_stage = 2'd3;
    flush_en    = 1'b1;
    flush_stage = 2'd3;
    rst_n       = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    if (stg_valid !== 4'b0000 || stg_ctrl !== 64'h0 || stg_pc !== 64'h0) begin
      $display("FAIL reset_mid_stall: got valid=%b ctrl=%h pc=%h expected all 0", stg_valid,
               stg_ctrl, stg_pc); failures++;
    end
    checks++;
  endtask

`ifdef LC3B_PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    stall_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall_en = 1'b0;
    flush_en = 1'b1;
    for (int i = 0; i < 2; i++) step();
    flush_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'(16'h8000 + 16'(2 * i)), 16'hA000, 16'h0800);
      step();
    end
    bus.valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 32'd2 || perf_retire_cnt !== 32'd7) begin
      $display("FAIL perf_counts: got %0d/%0d/%0d expected 5/2/7", perf_stall_cnt, perf_flush_cnt,
               perf_retire_cnt); failures++;
    end
    checks++;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_stall_flush();
    test_reset_mid_stall();
`ifdef LC3B_PIPE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
